uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Asynchronous serial receiver. It is the downstream stage of TxTop and consumes the out_data line.
//  Uses the same selectors (para, bd_rate, s_num, d_num) so that a matched pair loops back cleanly.
//  Generates its own 16x oversample tick from clk and recovers LSB-first frames.
//  Presents each received byte with a valid/ack handshake, plus parity, framing and overrun flags.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency in Hz
//  OVS      16          oversample ticks per bit; mid-bit sample point at tick OVS/2-1
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous reset, active-low
//  rx_in       in   1  serial line, idles high
//  para        in   2  parity select: 00 none, 01 odd, 10 even, 11 none
//  bd_rate     in   2  baud select: 00 1200, 01 2400, 10 4800, 11 9600
//  s_num       in   1  stop bits: 0 = one, 1 = two
//  d_num       in   1  data bits: 0 = seven, 1 = eight
//  rx_ack      in   1  consumer acknowledge; clears rx_valid
//  rx_data     out  8  received byte; bit 7 = 0 in 7-bit mode
//  rx_valid    out  1  level; high from frame completion until rx_ack
//  parity_err  out  1  parity mismatch for the byte on rx_data; valid while rx_valid
//  frame_err   out  1  a stop bit was sampled low; valid while rx_valid
//  overrun     out  1  sticky; set when a frame completes while rx_valid is high
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; rx_data = 8'h00; synchronizer flops = 1; FSM = IDLE.
//  - Input path: rx_in passes through a 2-flop synchronizer (rxs). All FSM decisions use rxs.
//  - Tick generator: divisor DIV = CLK_HZ/(baud*OVS), integer truncation.
//    - The counter restarts at 0 on start-edge detect. tick pulses 1 clk each DIV clks.
//  - Config latch: para, bd_rate, s_num and d_num are latched on start-edge detect.
//    - Changes mid-frame have no effect until the next frame.
//  - FSM:
//    - IDLE -> START on rxs 1->0.
//    - START: at tick count OVS/2-1, rxs=0 -> DATA. rxs=1 -> IDLE (glitch reject, no flags).
//    - DATA: sample rxs at each mid-bit, shifting LSB first, for 7 or 8 bits.
//      Then go to PARITY if parity is enabled, else STOP.
//    - PARITY: sample the parity bit. parity_err = (odd ? ~^bits : ^bits) ^ sample mismatch.
//      7-bit mode uses the 7 bits only.
//    - STOP: sample 1 or 2 stop bits. Any low sample sets frame_err. Then go to DONE.
//    - DONE (1 clk): load rx_data and the error flags, set rx_valid. If rx_valid was already high, set overrun.
//      Then -> IDLE. A new start edge is accepted on the next clk.
//  - Latency: rx_valid rises 1 clk after the mid-bit sample of the final stop bit.
//    Add the 2-clk synchronizer delay relative to the rx_in edge.
//  - Handshake:
//    - rx_ack with rx_valid high clears rx_valid on the next clk.
//    - rx_ack in the same clk as DONE: DONE wins (rx_valid stays 1, overrun set).
//    - rx_ack with rx_valid low is ignored.
//  - Overrun: new data overwrites rx_data. overrun clears only on reset.
//  - Frame error with rxs held low (break): after DONE, the FSM waits in IDLE for rxs=1.
//    It never re-triggers on a held-low line.
//  - Reset mid-frame: immediate return to IDLE and reset values, with no partial rx_valid.
// CONFIGURATION
//  - UART_RX_ERR_CNT_EN defined: adds outputs perr_cnt[7:0] and ferr_cnt[7:0].
//    - Each is an 8-bit saturating counter (stops at 8'hFF), incremented in DONE when its flag is set.
//    - Cleared by reset only.
//  - UART_RX_ERR_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. CLK_HZ=50M, bd_rate=11, d_num=1, para=00, s_num=0; send 8'hA5.
//     -> rx_valid=1, rx_data=A5, flags 0, busy low after DONE.
//  2. para=10 (even), send 8'h03 with a corrupted parity bit 1 -> rx_data=03, parity_err=1.
//     Repeat with parity bit 0 -> parity_err=0.
//  3. d_num=0, s_num=1; send 7'h55, drive the second stop bit low -> rx_data=8'h55, frame_err=1.
//  4. Send 8'h11 and 8'h22 back-to-back with no rx_ack -> rx_data=22, overrun=1.
//     Then rx_ack -> rx_valid=0 next clk, overrun still 1.
//  5. Drive a 3-clk low glitch on rx_in in IDLE -> FSM returns to IDLE, rx_valid stays 0.
//     Then a valid 8'h7E frame is received correctly.
//  6. Deassert-assert rst during the DATA bits of 8'hFF -> all outputs 0 immediately.
//     The next full frame 8'h0F is received. With UART_RX_ERR_CNT_EN: case 2 -> perr_cnt=1.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled asynchronous serial receiver with a valid/ack byte handshake.
// Define UART_RX_ERR_CNT_EN to add saturating parity/framing error counters (perr_cnt, ferr_cnt).
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] para,
  input  logic [1:0] bd_rate,
  input  logic       s_num,
  input  logic       d_num,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0] perr_cnt,
  output logic [7:0] ferr_cnt,
`endif
  output logic       busy
);

  localparam int DIV_1200 = CLK_HZ / (1200 * OVS);
  localparam int DIV_2400 = CLK_HZ / (2400 * OVS);
  localparam int DIV_4800 = CLK_HZ / (4800 * OVS);
  localparam int DIV_9600 = CLK_HZ / (9600 * OVS);
  localparam int DW = $clog2(DIV_1200 + 1);
  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OS_MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q, rxs_prev_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d, div_max;
  logic [OW-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [1:0]    para_q, para_d, bd_q, bd_d;
  logic          s2_q, s2_d, d8_q, d8_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    perr_cnt_q, perr_cnt_d, ferr_cnt_q, ferr_cnt_d;
`endif

  logic       start_edge, tick, sample, par_en, par_bit_exp;
  logic [7:0] data_byte;

  always_comb begin
    case (bd_q)
      2'b00:   div_max = DW'(DIV_1200 - 1);
      2'b01:   div_max = DW'(DIV_2400 - 1);
      2'b10:   div_max = DW'(DIV_4800 - 1);
      default: div_max = DW'(DIV_9600 - 1);
    endcase
  end

  // A held-low line never produces a new edge, so a break cannot retrigger the FSM.
  assign start_edge  = rxs_prev_q & ~rxs_q;
  assign tick        = (div_cnt_q == div_max);
  assign sample      = tick && (os_cnt_q == ((state_q == S_START) ? OS_MID : OS_LAST));
  assign par_en      = (para_q == 2'b01) || (para_q == 2'b10);
  assign data_byte   = d8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign par_bit_exp = (para_q == 2'b01) ? ~^data_byte : ^data_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_in;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      stop_cnt_q   <= 1'b0;
      para_q       <= '0;
      bd_q         <= '0;
      s2_q         <= 1'b0;
      d8_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      perr_cnt_q   <= '0;
      ferr_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      stop_cnt_q   <= stop_cnt_d;
      para_q       <= para_d;
      bd_q         <= bd_d;
      s2_q         <= s2_d;
      d8_q         <= d8_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_ERR_CNT_EN
      perr_cnt_q   <= perr_cnt_d;
      ferr_cnt_q   <= ferr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + DW'(1);
    os_cnt_d     = sample ? '0 : (tick ? os_cnt_q + OW'(1) : os_cnt_q);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    stop_cnt_d   = stop_cnt_q;
    para_d       = para_q;
    bd_d         = bd_q;
    s2_d         = s2_q;
    d8_d         = d8_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
`ifdef UART_RX_ERR_CNT_EN
    perr_cnt_d   = perr_cnt_q;
    ferr_cnt_d   = ferr_cnt_q;
`endif
    if (rx_ack && rx_valid_q) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        os_cnt_d  = '0;
        if (start_edge) begin
          state_d    = S_START;
          para_d     = para;
          bd_d       = bd_rate;
          s2_d       = s_num;
          d8_d       = d_num;
          bit_cnt_d  = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          stop_cnt_d = 1'b0;
        end
      end
      S_START: begin
        if (sample) state_d = rxs_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == (d8_q ? 3'd7 : 3'd6)) state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_acc_d = par_bit_exp ^ rxs_q;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!rxs_q) ferr_acc_d = 1'b1;
          stop_cnt_d = 1'b1;
          if (!s2_q || stop_cnt_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Completion overrides a same-cycle ack so the new byte is never lost.
        state_d      = S_IDLE;
        rx_data_d    = data_byte;
        parity_err_d = perr_acc_q;
        frame_err_d  = ferr_acc_q;
        rx_valid_d   = 1'b1;
        if (rx_valid_q) overrun_d = 1'b1;
`ifdef UART_RX_ERR_CNT_EN
        if (perr_acc_q && perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'd1;
        if (ferr_acc_q && ferr_cnt_q != 8'hFF) ferr_cnt_d = ferr_cnt_q + 8'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_ERR_CNT_EN
  assign perr_cnt   = perr_cnt_q;
  assign ferr_cnt   = ferr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int CLK_HZ = 1_228_800;

  logic       clk, rst, rx_in, s_num, d_num, rx_ack;
  logic [1:0] para, bd_rate;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] perr_cnt, ferr_cnt;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_valid = 1'b0;
  logic exp_ovr = 1'b0;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .OVS(16)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .para(para), .bd_rate(bd_rate),
    .s_num(s_num), .d_num(d_num), .rx_ack(rx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun),
`ifdef UART_RX_ERR_CNT_EN
    .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int bit_clks(input logic [1:0] b);
    int baud;
    baud = 1200 << b;
    return (CLK_HZ / (baud * 16)) * 16;
  endfunction

  // Frame-level reference: {expected byte, parity_err, frame_err}.
  function automatic logic [9:0] model_rx(input logic [7:0] d, input logic d8, input logic [1:0] par,
                                          input logic pbit, input logic s2, input logic [1:0] stop_low);
    logic [7:0] v;
    int         ones;
    logic       pe, fe;
    v    = d8 ? d : {1'b0, d[6:0]};
    ones = $countones(v) + (pbit ? 1 : 0);
    pe   = 1'b0;
    if (par == 2'b01) pe = (ones % 2) == 0;
    else if (par == 2'b10) pe = (ones % 2) == 1;
    fe   = stop_low[0] | (s2 & stop_low[1]);
    return {v, pe, fe};
  endfunction

  task automatic note_frame();
    if (exp_valid) exp_ovr = 1'b1;
    exp_valid = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic d8, input logic [1:0] par, input logic pbit,
                            input logic s2, input logic [1:0] brate, input logic [1:0] stop_low,
                            input logic scramble, input logic restore);
    int bc, nb;
    bc = bit_clks(brate);
    nb = d8 ? 8 : 7;
    @(negedge clk);
    para = par; bd_rate = brate; s_num = s2; d_num = d8;
    repeat (2) @(negedge clk);
    rx_in = 1'b0;
    repeat (bc) @(negedge clk);
    if (scramble) begin
      para = 2'($urandom); bd_rate = 2'($urandom); s_num = 1'($urandom); d_num = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) begin
      rx_in = d[i];
      repeat (bc) @(negedge clk);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rx_in = pbit;
      repeat (bc) @(negedge clk);
    end
    for (int s = 0; s < (s2 ? 2 : 1); s++) begin
      rx_in = ~stop_low[s];
      repeat (bc) @(negedge clk);
    end
    if (restore) rx_in = 1'b1;
  endtask

  task automatic do_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=0", {rx_data, rx_valid, parity_err, frame_err, overrun, busy});
    end
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [9:0] e;
    int bc;
    bc = bit_clks(2'b11);
    e  = model_rx(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    fork
      send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
      begin
        repeat (3 + 9 * bc + bc / 2 + 2) @(negedge clk);
        vectors++;
        if ({rx_valid, busy} !== 2'b01) begin
          miscompares++; $display("FAIL basic_early valid,busy=%b exp=01", {rx_valid, busy});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_valid, busy} !== 2'b10) begin
          miscompares++; $display("FAIL basic_latency valid,busy=%b exp=10", {rx_valid, busy});
        end
      end
    join
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL basic_A5 got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
    vectors++;
    if ({rx_valid, overrun} !== {1'b0, exp_ovr}) begin
      miscompares++; $display("FAIL basic_ack valid,ovr=%b exp=%b", {rx_valid, overrun}, {1'b0, exp_ovr});
    end
  endtask

  task automatic test_parity();
    logic [9:0] e;
    for (int k = 0; k < 2; k++) begin
      logic pb;
      pb = (k == 0);
      e = model_rx(8'h03, 1'b1, 2'b10, pb, 1'b0, 2'b00);
      send_frame(8'h03, 1'b1, 2'b10, pb, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
      for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
      note_frame();
      vectors++;
      if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
        miscompares++;
        $display("FAIL parity_even_pb%0d got=%h exp=%h", pb, {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
      end
`ifdef UART_RX_ERR_CNT_EN
      vectors++;
      if ({perr_cnt, ferr_cnt} !== 16'h0100) begin
        miscompares++; $display("FAIL perr_cnt got=%h exp=0100", {perr_cnt, ferr_cnt});
      end
`endif
      do_ack();
    end
  endtask

  task automatic test_frame7();
    logic [9:0] e;
    e = model_rx(8'h55, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
    send_frame(8'h55, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1);
    for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL frame7_stop2 got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
  endtask

  task automatic test_glitch();
    logic [9:0] e;
    int bc;
    bc = bit_clks(2'b11);
    @(negedge clk); bd_rate = 2'b11; d_num = 1'b1; para = 2'b00; s_num = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL glitch_start busy=%b exp=1", busy);
    end
    repeat (bc) @(negedge clk);
    vectors++;
    if ({busy, rx_valid} !== 2'b00) begin
      miscompares++; $display("FAIL glitch_reject busy,valid=%b exp=00", {busy, rx_valid});
    end
    e = model_rx(8'h7E, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    send_frame(8'h7E, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL glitch_7E got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       d8, pb, s2;
    logic [1:0] par, br, sl;
    logic [9:0] e;
    for (int n = 0; n < 6; n++) begin
      d   = 8'($urandom);
      d8  = 1'($urandom);
      par = 2'($urandom);
      pb  = 1'($urandom);
      s2  = 1'($urandom);
      br  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      sl  = 2'($urandom) & (($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00);
      e   = model_rx(d, d8, par, pb, s2, sl);
      send_frame(d, d8, par, pb, s2, br, sl, 1'b1, 1'b1);
      for (int w = 0; w < 800 && !rx_valid; w++) @(negedge clk);
      note_frame();
      vectors++;
      if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
        miscompares++;
        $display("FAIL random_%0d d=%h d8=%b par=%b pb=%b s2=%b br=%b sl=%b got=%h exp=%h", n, d, d8, par, pb, s2, br, sl,
                 {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
      end
      do_ack();
      vectors++;
      if (rx_valid !== 1'b0) begin
        miscompares++; $display("FAIL random_ack_%0d valid=%b exp=0", n, rx_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
    note_frame();
    e = model_rx(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL overrun_22 got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
    vectors++;
    if ({rx_valid, overrun} !== {1'b0, exp_ovr}) begin
      miscompares++; $display("FAIL overrun_ack valid,ovr=%b exp=%b", {rx_valid, overrun}, {1'b0, exp_ovr});
    end
  endtask

  task automatic test_break();
    logic [9:0] e;
    int bc;
    bc = bit_clks(2'b11);
    e  = model_rx(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01);
    send_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL break_frame got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
    repeat (3 * bc) @(negedge clk);
    vectors++;
    if ({rx_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL break_hold valid,busy=%b exp=00", {rx_valid, busy});
    end
    rx_in = 1'b1;
    repeat (bc) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [9:0] e;
    int bc;
    bc = bit_clks(2'b11);
    @(negedge clk); para = 2'b00; bd_rate = 2'b11; s_num = 1'b0; d_num = 1'b1;
    repeat (2) @(negedge clk);
    rx_in = 1'b0;
    repeat (bc) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * bc + bc / 2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL midframe_busy busy=%b exp=1", busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL midframe_reset got=%h exp=0", {rx_data, rx_valid, parity_err, frame_err, overrun, busy});
    end
`ifdef UART_RX_ERR_CNT_EN
    vectors++;
    if ({perr_cnt, ferr_cnt} !== 16'h0) begin
      miscompares++; $display("FAIL midframe_cnt got=%h exp=0", {perr_cnt, ferr_cnt});
    end
`endif
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (6 * bc) @(negedge clk);
    vectors++;
    if ({rx_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL midframe_partial valid,busy=%b exp=00", {rx_valid, busy});
    end
    e = model_rx(8'h0F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    send_frame(8'h0F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int w = 0; w < 400 && !rx_valid; w++) @(negedge clk);
    note_frame();
    vectors++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun} !== {1'b1, e, exp_ovr}) begin
      miscompares++;
      $display("FAIL midframe_0F got=%h exp=%h", {rx_valid, rx_data, parity_err, frame_err, overrun}, {1'b1, e, exp_ovr});
    end
    do_ack();
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; rx_ack = 1'b0;
    para = 2'b00; bd_rate = 2'b11; s_num = 1'b0; d_num = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_frame7();
    test_glitch();
    test_random();
    test_back_to_back();
    test_break();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
